// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings and FSM state codes shared by the slave memory
package axi_pkg;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_type_en;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_type_en;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts and WRAP length legality
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_ok
);
  logic [ADDR_WIDTH-1:0] step, aligned, mask;
  assign step = ADDR_WIDTH'(1) << size;
  assign aligned = addr & ~(step - ADDR_WIDTH'(1));
  // mask spans the wrap window of (len+1) transfers
  assign mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign wrap_ok = burst != WRAP || len inside {4'd1, 4'd3, 4'd7, 4'd15};
  assign next_addr = burst == FIXED ? addr
                   : burst == WRAP  ? (addr & ~mask) | ((aligned + step) & mask)
                   : aligned + step;
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 slave responder backed by a word-addressed RAM with byte strobes
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  output logic                  AWREADY,
  input  logic                  WVALID,
  input  logic [ID_WIDTH-1:0]   WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic                  BVALID,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  input  logic                  BREADY,
  input  logic                  ARVALID,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  output logic                  ARREADY,
  output logic                  RVALID,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  input  logic                  RREADY
);
  localparam int LB = $clog2(STRB_WIDTH);
  localparam int IW = $clog2(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic up;
  logic [1:0] wstate;
  logic [ADDR_WIDTH-1:0] aw_addr, w_next, w_idx;
  logic [3:0] aw_len, wcnt;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic werr, w_wrap_ok, w_noop, w_oob, w_hs, w_last, w_err;
  logic rstate;
  logic [ADDR_WIDTH-1:0] ar_addr, r_in, r_next, r_addr, r_idx;
  logic [3:0] ar_len, r_len, rcnt;
  logic [2:0] ar_size, r_size;
  logic [1:0] ar_burst, r_burst;
  logic r_wrap_ok, r_bad;
  logic [DATA_WIDTH-1:0] r_data;
  // ready lines stay low until the first edge after reset release
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) up <= 1'b0;
    else up <= 1'b1;
  assign AWREADY = up && wstate == W_IDLE;
  assign WREADY  = wstate == W_DATA;
  assign BVALID  = wstate == W_RESP;
  assign w_idx   = aw_addr >> LB;
  assign w_oob   = w_idx >= ADDR_WIDTH'(MEM_DEPTH);
  assign w_noop  = aw_size > 3'(LB) || !w_wrap_ok;
  assign w_hs    = WREADY && WVALID;
  assign w_last  = wcnt == aw_len;
  assign w_err   = w_noop || w_oob || WID != BID || WLAST != w_last;
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
    .addr(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst),
    .next_addr(w_next), .wrap_ok(w_wrap_ok)
  );
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      wstate   <= W_IDLE;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      wcnt     <= '0;
      werr     <= 1'b0;
      BID      <= '0;
      BRESP    <= OKAY;
    end else if (AWREADY && AWVALID) begin
      wstate   <= W_DATA;
      aw_addr  <= AWADDR;
      aw_len   <= AWLEN;
      aw_size  <= AWSIZE;
      aw_burst <= AWBURST;
      BID      <= AWID;
      wcnt     <= '0;
      werr     <= 1'b0;
    end else if (w_hs) begin
      aw_addr <= w_next;
      wcnt    <= wcnt + 4'd1;
      werr    <= werr || w_err;
      if (w_last) begin
        wstate <= W_RESP;
        BRESP  <= (werr || w_err) ? SLVERR : OKAY;
      end
    end else if (BVALID && BREADY) wstate <= W_IDLE;
  always_ff @(posedge ACLK)
    if (w_hs && !w_noop && !w_oob)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (WSTRB[i]) mem[w_idx[IW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
  // the read generator sees the incoming request while idle, the active burst otherwise
  assign ARREADY = up && rstate == R_IDLE;
  assign RVALID  = rstate == R_DATA;
  assign r_in    = RVALID ? ar_addr : ARADDR;
  assign r_len   = RVALID ? ar_len : ARLEN;
  assign r_size  = RVALID ? ar_size : ARSIZE;
  assign r_burst = RVALID ? ar_burst : ARBURST;
  assign r_addr  = RVALID ? r_next : ARADDR;
  assign r_idx   = r_addr >> LB;
  assign r_bad   = r_size > 3'(LB) || !r_wrap_ok || r_idx >= ADDR_WIDTH'(MEM_DEPTH);
  assign r_data  = r_bad ? '0 : mem[r_idx[IW-1:0]];
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
    .addr(r_in), .len(r_len), .size(r_size), .burst(r_burst),
    .next_addr(r_next), .wrap_ok(r_wrap_ok)
  );
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      rstate   <= R_IDLE;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      rcnt     <= '0;
      RID      <= '0;
      RDATA    <= '0;
      RRESP    <= OKAY;
      RLAST    <= 1'b0;
    end else if (ARREADY && ARVALID) begin
      rstate   <= R_DATA;
      ar_addr  <= ARADDR;
      ar_len   <= ARLEN;
      ar_size  <= ARSIZE;
      ar_burst <= ARBURST;
      RID      <= ARID;
      rcnt     <= '0;
      RDATA    <= r_data;
      RRESP    <= r_bad ? SLVERR : OKAY;
      RLAST    <= ARLEN == 4'd0;
    end else if (RVALID && RREADY) begin
      if (RLAST) begin
        rstate <= R_IDLE;
        RLAST  <= 1'b0;
      end else begin
        ar_addr <= r_next;
        rcnt    <= rcnt + 4'd1;
        RDATA   <= r_data;
        RRESP   <= r_bad ? SLVERR : OKAY;
        RLAST   <= rcnt + 4'd1 == ar_len;
      end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed and random AXI bursts checked against a byte-level memory model
module tb_axi_slave_mem;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [3:0] AWID = 0, WID = 0, ARID = 0, AWLEN = 0, ARLEN = 0, WSTRB = 0;
  logic [31:0] AWADDR = 0, ARADDR = 0, WDATA = 0;
  logic [2:0] AWSIZE = 0, ARSIZE = 0;
  logic [1:0] AWBURST = 0, ARBURST = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [3:0] BID, RID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  int nvec = 0, nerr = 0;
  logic [31:0] ref_mem [256];

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWREADY(AWREADY),
    .WVALID(WVALID), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BID(BID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREADY(ARREADY),
    .RVALID(RVALID), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // i-th beat address computed directly from the burst rules
  function automatic int unsigned beat_addr(int unsigned a, int len, int size, int burst, int i);
    int unsigned step, al, wb, base;
    step = 1 << size;
    al = a / step * step;
    if (i == 0 || burst == 0) return a;
    if (burst == 2) begin
      wb = (len + 1) * step;
      base = a / wb * wb;
      return base + (al - base + i * step) % wb;
    end
    return al + i * step;
  endfunction

  function automatic bit bad_cfg(int len, int size, int burst);
    return size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  task automatic do_write(input logic [3:0] id, input int unsigned addr, input int len, input int size,
                          input int burst, input int bad_id, input int bad_last,
                          input logic [3:0] strb, input logic [31:0] d0, input bit rnd);
    int unsigned a;
    logic [31:0] d;
    logic [3:0] s;
    logic [7:0] w;
    bit err;
    int n;
    err = bad_cfg(len, size, burst);
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1;
    n = 0;
    while (!AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("awready", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 0;
    chk("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 0; @(posedge ACLK); #1; end
      a = beat_addr(addr, len, size, burst, i);
      d = rnd ? $urandom : d0 + i;
      s = strb == 0 ? 4'($urandom) : strb;
      WID = i == bad_id ? id ^ 4'd1 : id;
      WLAST = (i == len) ^ (i == bad_last);
      WDATA = d; WSTRB = s; WVALID = 1;
      if (i == bad_id || i == bad_last) err = 1;
      if (!bad_cfg(len, size, burst)) begin
        if (a / 4 >= 256) err = 1;
        else begin
          w = 8'(a / 4);
          for (int j = 0; j < 4; j++) if (s[j]) ref_mem[w][j*8 +: 8] = d[j*8 +: 8];
        end
      end
      n = 0;
      while (!WREADY && n < 50) begin @(posedge ACLK); #1; n++; end
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0;
    chk("bvalid", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, err ? 2 : 0);
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    chk("b_done", BVALID, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input int unsigned addr, input int len, input int size,
                         input int burst, input int stall_at, input int stall_len, input bit rnd_rdy);
    logic [34:0] exp_beat [16];
    int unsigned a;
    int k, n, st;
    bit rdy;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (bad_cfg(len, size, burst) || a / 4 >= 256) exp_beat[i] = {32'h0, 2'd2, i == len};
      else exp_beat[i] = {ref_mem[8'(a / 4)], 2'd0, i == len};
    end
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst); ARVALID = 1;
    n = 0;
    while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("arready", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 0;
    k = 0; n = 0; st = 0;
    while (k <= len && n < 200) begin
      if (k == stall_at && st < stall_len) begin rdy = 0; st++; end
      else rdy = rnd_rdy ? $urandom_range(0, 3) != 0 : 1;
      RREADY = rdy;
      chk("rvalid", RVALID, 1);
      chk("rbeat", {RDATA, RRESP, RLAST}, exp_beat[k]);
      chk("rid", RID, id);
      if (rdy) k++;
      @(posedge ACLK); #1;
      n++;
    end
    RREADY = 0;
    chk("rbeats", k, len + 1);
    chk("r_done", RVALID, 0);
  endtask

  initial begin
    int unsigned addr;
    int len, size, burst;
    logic [3:0] id;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_valids", {WREADY, BVALID, RVALID, RLAST}, 0);
    chk("rst_ids", {BID, RID}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_resps", {BRESP, RRESP}, 0);
    ARESET = 0;
    chk("rel_awready_low", AWREADY, 0);
    @(posedge ACLK); #1;
    chk("rel_awready", AWREADY, 1);
    chk("rel_arready", ARREADY, 1);
    for (int b = 0; b < 16; b++) do_write(4'(b), b * 64, 15, 2, 1, -1, -1, 4'hF, 0, 1);
    // basic INCR write and readback
    do_write(4'h3, 'h10, 3, 2, 1, -1, -1, 4'hF, 32'hA0, 0);
    do_read(4'h5, 'h10, 3, 2, 1, -1, 0, 0);
    chk("a2_value", ref_mem[8'h06], 32'hA2);
    do_read(4'h6, 'h38, 3, 2, 2, -1, 0, 0);
    // byte strobes
    do_write(4'h1, 'h80, 0, 2, 1, -1, -1, 4'hF, 32'h12345678, 0);
    do_write(4'h1, 'h80, 0, 2, 1, -1, -1, 4'b0101, 32'hFFFFFFFF, 0);
    do_read(4'h1, 'h80, 0, 2, 1, -1, 0, 0);
    chk("strb_model", ref_mem[8'h20], 32'h12FF56FF);
    // last word plus one beat past the end
    do_write(4'h2, 'h3FC, 1, 2, 1, -1, -1, 4'hF, 32'h5A5A0000, 0);
    do_read(4'h2, 'h3FC, 1, 2, 1, -1, 0, 0);
    // oversize, illegal wrap length, bad WID, misplaced WLAST
    do_write(4'h7, 'h40, 1, 3, 1, -1, -1, 4'hF, 0, 1);
    do_read(4'h7, 'h40, 1, 3, 1, -1, 0, 0);
    do_read(4'h7, 'h40, 3, 2, 1, -1, 0, 0);
    do_write(4'h8, 'h60, 2, 2, 2, -1, -1, 4'hF, 0, 1);
    do_read(4'h8, 'h60, 2, 2, 2, -1, 0, 0);
    do_read(4'h8, 'h60, 3, 2, 1, -1, 0, 0);
    do_write(4'h9, 'hA0, 3, 2, 1, 1, -1, 4'hF, 0, 1);
    do_read(4'h9, 'hA0, 3, 2, 1, -1, 0, 0);
    do_write(4'hA, 'hB0, 3, 2, 1, -1, 2, 4'hF, 0, 1);
    do_read(4'hA, 'hB0, 3, 2, 1, -1, 0, 0);
    // stalled read alongside an independent write
    fork
      do_read(4'h4, 'h200, 7, 2, 1, 3, 5, 0);
      do_write(4'hB, 'h300, 7, 2, 1, -1, -1, 4'hF, 0, 1);
    join
    do_read(4'hB, 'h300, 7, 2, 1, -1, 0, 1);
    // reset while beat 2 of a 4-beat read is presented
    ARID = 4'hC; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1;
    @(posedge ACLK); #1;
    ARVALID = 0; RREADY = 1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    chk("rst_mid_beat2", RDATA, ref_mem[8'h42]);
    ARESET = 1;
    #1;
    chk("rst_mid_rvalid", RVALID, 0);
    RREADY = 0;
    @(posedge ACLK); #1;
    chk("rst_mid_rvalid_next", RVALID, 0);
    chk("rst_mid_arready", ARREADY, 0);
    ARESET = 0;
    @(posedge ACLK); #1;
    chk("rst_rel_arready", ARREADY, 1);
    chk("rst_rel_awready", AWREADY, 1);
    do_read(4'hD, 'h100, 3, 2, 1, -1, 0, 0);
    // random bursts
    for (int t = 0; t < 30; t++) begin
      id = 4'($urandom);
      size = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
      burst = $urandom_range(0, 2);
      len = $urandom_range(0, 15);
      addr = $urandom_range(0, 'h43F);
      if (burst == 2) addr = addr / (1 << size) * (1 << size);
      do_write(id, addr, len, size, burst, $urandom_range(0, 7) == 0 ? 0 : -1, -1, 4'h0, 0, 1);
      do_read(id, addr, len, size, burst, -1, 0, 1);
      do_read(id ^ 4'hF, $urandom_range(0, 'h3FF) & ~32'h3, $urandom_range(0, 15), 2, 1,
              $urandom_range(0, 4), $urandom_range(0, 3), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
